// File: rtl/wb_seq_pkg.sv
// Shared types, default constants and pattern helper for the Wishbone
// write-then-readback sequencer.
package wb_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    GAP,
    READ,
    FINISH
  } state_t;

  localparam logic [31:0] SEED_DEF       = 32'hA5A5_0000;
  localparam int          GAP_CYCLES_DEF = 10;
  localparam int          TIMEOUT_DEF    = 15;

  // Word expected at address a: seed + a, wrapping at 32 bits.
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] a);
    return seed + a;
  endfunction

endpackage

// File: rtl/wb_seq_watchdog.sv
// Counts strobe cycles without an acknowledge; expire fires on the cycle
// whose edge would bring the count to TIMEOUT.
module wb_seq_watchdog import wb_seq_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  input  logic clr,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: restart on every ack or whenever the strobe is idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !stb || ack) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = stb & ~ack & (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_seq_master.sv
// Wishbone classic-cycle initiator: writes a seed+address pattern to every
// word, idles for a gap, reads everything back and counts miscompares.
module wb_seq_master import wb_seq_pkg::*; #(
  parameter int            AW         = 3,
  parameter int            DW         = 32,
  parameter logic [DW-1:0] SEED       = DW'(SEED_DEF),
  parameter int            GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int            TIMEOUT    = TIMEOUT_DEF
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          start,
  input  logic          ACK_I,
  input  logic [DW-1:0] DAT_I,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  output logic [AW-1:0] ADR_O,
  output logic [DW-1:0] DAT_O,
  output logic          busy,
  output logic          done,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] fail_adr,
  output logic          timeout
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        state_q;
  logic [AW:0]   addr_q;
  logic [AW:0]   addr_nxt;
  logic [GW-1:0] gap_q;
  logic          cyc_q, stb_q, we_q;
  logic [DW-1:0] dat_q;
  logic          busy_q, done_q, tmo_q;
  logic [7:0]    err_q;
  logic [AW-1:0] fadr_q;
  logic          expire;
  logic          phase_last;
  logic          ack_edge;

  function automatic logic [DW-1:0] word_at(input logic [AW:0] a);
    return DW'(pat(32'(SEED), 32'(a)));
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The carry out of the address counter marks the last word of a phase.
  assign addr_nxt   = addr_q + (AW + 1)'(1);
  assign phase_last = addr_nxt[AW];
  assign ack_edge   = stb_q & ACK_I;

  wb_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (CLK_I),
    .rst    (RST_I),
    .stb    (stb_q),
    .ack    (ACK_I),
    .clr    (state_q == IDLE),
    .expire (expire)
  );

  // Sequencer FSM with registered bus signals, gap counter and error tracking.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      addr_q  <= '0;
      gap_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= '0;
      fadr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if ((state_q == WRITE || state_q == READ) && expire) begin
        // Responder went silent: abandon the pass without further transfers.
        tmo_q   <= 1'b1;
        cyc_q   <= 1'b0;
        stb_q   <= 1'b0;
        we_q    <= 1'b0;
        dat_q   <= '0;
        addr_q  <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        state_q <= FINISH;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= WRITE;
              addr_q  <= '0;
              err_q   <= '0;
              fadr_q  <= '0;
              tmo_q   <= 1'b0;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b1;
              dat_q   <= word_at('0);
              busy_q  <= 1'b1;
            end
          end
          WRITE: begin
            if (ack_edge) begin
              if (phase_last) begin
                state_q <= GAP;
                addr_q  <= '0;
                gap_q   <= '0;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                we_q    <= 1'b0;
                dat_q   <= '0;
              end else begin
                addr_q <= addr_nxt;
                dat_q  <= word_at(addr_nxt);
              end
            end
          end
          GAP: begin
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
              state_q <= READ;
              gap_q   <= '0;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          READ: begin
            if (ack_edge) begin
              if (DAT_I != word_at(addr_q)) begin
                err_q <= sat_inc(err_q);
                if (err_q == 8'd0) begin
                  fadr_q <= addr_q[AW-1:0];
                end
              end
              if (phase_last) begin
                state_q <= FINISH;
                addr_q  <= '0;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                addr_q <= addr_nxt;
              end
            end
          end
          FINISH: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign CYC_O    = cyc_q;
  assign STB_O    = stb_q;
  assign WE_O     = we_q;
  assign ADR_O    = addr_q[AW-1:0];
  assign DAT_O    = dat_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_cnt  = err_q;
  assign fail_adr = fadr_q;
  assign timeout  = tmo_q;

endmodule

// File: tb/tb_wb_seq_master.sv
// Directed bench for wb_seq_master with a small behavioural responder.
module tb_wb_seq_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ACK_I;
  logic [31:0] DAT_I;
  logic        CYC_O, STB_O, WE_O;
  logic [2:0]  ADR_O;
  logic [31:0] DAT_O;
  logic        busy, done, timeout;
  logic [7:0]  err_cnt;
  logic [2:0]  fail_adr;

  // responder controls (written only by the main initial block)
  logic        ack_en = 1'b1;
  logic [3:0]  nwait = 4'd0;
  logic        bad = 1'b0;
  logic        force_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  wb_seq_master dut (
    .CLK_I(clk), .RST_I(rst), .start(start), .ACK_I(ACK_I), .DAT_I(DAT_I),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .busy(busy), .done(done), .err_cnt(err_cnt), .fail_adr(fail_adr),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // responder: memory plus programmable wait states
  logic [31:0] mem [0:7];
  logic [3:0]  wcnt;
  assign ACK_I = force_ack | (ack_en & STB_O & CYC_O & (wcnt == nwait));
  assign DAT_I = (bad && !WE_O && (ADR_O == 3'd5 || ADR_O == 3'd6)) ? 32'hDEAD_BEEF : mem[ADR_O];

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 4'd0;
    else if (STB_O && ACK_I) wcnt <= 4'd0;
    else if (STB_O) wcnt <= wcnt + 4'd1;
    else wcnt <= 4'd0;
  end

  // bus monitor: edge stamps, transfer counts, write data and hold checks
  int cyc_cnt = 0;
  int xfers = 0;
  int bad_wr = 0;
  int viol = 0;
  int wr_last_e = 0;
  int rd0_e = 0;
  logic        hold_pend = 1'b0;
  logic [2:0]  hold_adr;
  logic [31:0] hold_dat;
  logic        hold_we;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (hold_pend && !(STB_O && ADR_O == hold_adr && DAT_O == hold_dat && WE_O == hold_we))
      viol <= viol + 1;
    hold_pend <= STB_O && !ACK_I;
    hold_adr  <= ADR_O;
    hold_dat  <= DAT_O;
    hold_we   <= WE_O;
    if (STB_O && ACK_I) begin
      xfers <= xfers + 1;
      if (WE_O) begin
        mem[ADR_O] <= DAT_O;
        if (DAT_O !== 32'hA5A5_0000 + 32'(ADR_O)) bad_wr <= bad_wr + 1;
        if (ADR_O == 3'd7) wr_last_e <= cyc_cnt + 1;
      end else if (ADR_O == 3'd0) begin
        rd0_e <= cyc_cnt + 1;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " CYC_O"}, CYC_O, 0);
    chk({tag, " STB_O"}, STB_O, 0);
    chk({tag, " WE_O"}, WE_O, 0);
    chk({tag, " ADR_O"}, ADR_O, 0);
    chk({tag, " DAT_O"}, DAT_O, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err_cnt"}, err_cnt, 0);
    chk({tag, " fail_adr"}, fail_adr, 0);
    chk({tag, " timeout"}, timeout, 0);
  endtask

  typedef struct {
    string      name;
    logic [3:0] nwait;
    logic       bad;
    logic       glitch;
    int         done_e;
    int         wrl_e;
    int         rd0_e;
    int         err;
    int         fadr;
  } vec_t;

  vec_t vecs [4];

  // Pulse start, then follow the pass until done (bounded).
  task automatic run_pass(input vec_t v);
    int e0, x0, bw0, vi0, de, dcount;
    nwait  = v.nwait;
    bad    = v.bad;
    ack_en = 1'b1;
    x0  = xfers;
    bw0 = bad_wr;
    vi0 = viol;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    e0 = cyc_cnt;
    chk({v.name, " STB after edge0"}, STB_O, 1);
    chk({v.name, " busy after edge0"}, busy, 1);
    de = -1;
    for (int i = 1; i < 200; i++) begin
      @(posedge clk) #1;
      if (done) begin
        de = i;
        break;
      end
      start     = v.glitch && (i == 3);
      force_ack = v.glitch && (i == 12);
    end
    start     = 1'b0;
    force_ack = 1'b0;
    chk({v.name, " done edge"}, de, v.done_e);
    chk({v.name, " last write ack edge"}, wr_last_e - e0, v.wrl_e);
    chk({v.name, " first read ack edge"}, rd0_e - e0, v.rd0_e);
    chk({v.name, " err_cnt"}, err_cnt, v.err);
    chk({v.name, " fail_adr"}, fail_adr, v.fadr);
    chk({v.name, " timeout"}, timeout, 0);
    chk({v.name, " busy at done"}, busy, 0);
    chk({v.name, " transfers"}, xfers - x0, 16);
    chk({v.name, " bad write data"}, bad_wr - bw0, 0);
    chk({v.name, " hold violations"}, viol - vi0, 0);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1;
      if (done) dcount++;
    end
    chk({v.name, " extra done pulses"}, dcount, 0);
  endtask

  initial begin
    int x0, dcount;
    vecs[0] = '{"zero-wait", 4'd0, 1'b0, 1'b0, 26, 8, 19, 0, 0};
    vecs[1] = '{"two-wait", 4'd2, 1'b0, 1'b0, 58, 24, 37, 0, 0};
    vecs[2] = '{"corrupt-5-6", 4'd0, 1'b1, 1'b0, 26, 8, 19, 2, 5};
    vecs[3] = '{"ignored-inputs", 4'd0, 1'b0, 1'b1, 26, 8, 19, 0, 0};

    #12;
    chk_idle_outputs("reset");
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 4; k++) run_pass(vecs[k]);

    // never-acking responder: watchdog abort
    ack_en = 1'b0;
    nwait  = 4'd0;
    bad    = 1'b0;
    x0 = xfers;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("timeout STB at cycle 15", STB_O, 1);
    chk("timeout flag before expiry", timeout, 0);
    @(posedge clk) #1;
    chk("timeout flag", timeout, 1);
    chk("timeout CYC dropped", CYC_O, 0);
    chk("timeout STB dropped", STB_O, 0);
    chk("timeout done", done, 1);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1;
      if (done) dcount++;
    end
    chk("timeout done single pulse", dcount, 0);
    chk("timeout transfers", xfers - x0, 0);
    chk("timeout busy", busy, 0);
    ack_en = 1'b1;

    // asynchronous reset in the middle of the read at address 3
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    chk("pre-reset STB", STB_O, 1);
    chk("pre-reset ADR", ADR_O, 3);
    chk("pre-reset WE", WE_O, 0);
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("async reset");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    run_pass(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // absolute guard against a hung run
  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/wb_seq_master.md
# wb_seq_master

Synthesizable Wishbone classic-cycle initiator that runs a write-then-readback self-test against a single Wishbone responder, such as one of the small MEMORY-library register files. On a start pulse it writes a deterministic pattern to every address, idles for a fixed gap, reads every address back, and compares each word. It reports a pass/fail summary and a bus-timeout flag. It sits beside a responder in a library test harness or in a built-in self-test wrapper.

## Interface
- `AW`, 3, address width; the pass covers 2^AW words.
- `DW`, 32, data width.
- `SEED`, 32'hA5A5_0000, pattern base; the word for address a is (SEED + a) mod 2^DW.
- `GAP_CYCLES`, 10, number of idle cycles between the write phase and the read phase.
- `TIMEOUT`, 15, maximum number of cycles STB_O may wait for ACK_I.
- `CLK_I`  in  1  clock; all state changes on the rising edge.
- `RST_I`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `ACK_I`  in  1  responder acknowledge.
- `DAT_I`  in  DW  read data from the responder.
- `CYC_O`  out  1  bus cycle active.
- `STB_O`  out  1  strobe.
- `WE_O`  out  1  1 = write.
- `ADR_O`  out  AW  address.
- `DAT_O`  out  DW  write data.
- `busy`  out  1  high from the start-sample edge until FINISH.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `err_cnt`  out  8  miscompare count; saturates at 255.
- `fail_adr`  out  AW  address of the first miscompare.
- `timeout`  out  1  the pass was aborted because no ACK arrived.

## Operation
- **Reset values:** all outputs are 0 and the FSM is in IDLE. Reset is asynchronous and active-high; assertion at any point, including mid-transfer, immediately drops CYC_O and STB_O.
- **FSM states:**
  - IDLE: when start=1 → WRITE. The same edge clears err_cnt, fail_adr and timeout, and sets the address counter to 0.
  - WRITE: drives CYC_O=STB_O=WE_O=1, ADR_O=a, DAT_O=SEED+a. On an edge with STB_O&ACK_I, a increments. The ack on a=2^AW−1 → GAP, and a wraps to 0.
  - GAP: drives CYC_O=STB_O=WE_O=0. After exactly GAP_CYCLES cycles → READ.
  - READ: drives CYC_O=STB_O=1, WE_O=0, ADR_O=a, DAT_O=0. On an ack edge, compare DAT_I with SEED+a. On mismatch, err_cnt saturating-increments; if err_cnt was 0, fail_adr←a. The ack on the last address → FINISH.
  - FINISH: done=1 and busy=0 for one cycle, then → IDLE.
- **Address counter:** AW+1 bits internally. ADR_O is the low AW bits. The carry bit marks the end of a phase.
- **Wait states:** while ACK_I=0, ADR_O, DAT_O, WE_O and STB_O hold their values.
- **Watchdog:** counts cycles with STB_O=1 and ACK_I=0, and resets to 0 on every ack. When the count reaches TIMEOUT, timeout←1, STB_O and CYC_O drop on that edge, and the FSM → FINISH. The pass is aborted with no further transfers.
- **Ignored inputs:**
  - ACK_I while STB_O=0 (IDLE, GAP, FINISH).
  - start outside IDLE.
- **Saturation:** err_cnt stays at 255 once reached.

## Timing
- Edge 0 is the edge that samples start. STB_O rises in the cycle after edge 0.
- With a zero-wait responder (combinational ACK):
  - write acks on edges 1..2^AW;
  - GAP occupies the next GAP_CYCLES cycles;
  - read acks follow back-to-back;
  - done is high in the cycle after the last read ack.
- STB_O stays high between consecutive transfers in the same phase. There is no idle cycle inside a phase.
- Each transfer takes 1 + (number of wait cycles) clock cycles.
- Read compare uses the DAT_I value present on the ack edge.
- err_cnt and fail_adr update on that same edge and are visible in the next cycle.

## Structure
- **Package `wb_seq_pkg`:**
  - state enum: IDLE, WRITE, GAP, READ, FINISH;
  - default SEED, GAP_CYCLES and TIMEOUT constants;
  - a pattern function pat(a) = SEED + a.
- **Sub-module `wb_seq_watchdog`:** a TIMEOUT counter with inputs stb, ack, clr and output expire.
- The top level holds the FSM, the address counter, the GAP counter and the compare/error logic.

## Test plan
1. **Zero-wait responder, AW=3:** start at edge 0 →
   - writes of 0xA5A50000..0xA5A50007 to addresses 0..7 acked on edges 1..8;
   - CYC_O low for 10 cycles;
   - reads acked on edges 19..26;
   - done high in cycle 27, err_cnt=0, timeout=0.
2. **Responder with 2 wait states:** each transfer occupies 3 cycles, with ADR_O and DAT_O stable throughout → done in cycle 59, err_cnt=0.
3. **Responder returns 0xDEADBEEF at addresses 5 and 6 on read** → err_cnt=2, fail_adr=5, done pulses once.
4. **Responder never acks:** STB_O is high for cycles 1..15 → at edge 15 timeout=1 and CYC_O drops, then done=1 for one cycle; zero transfers completed.
5. **Reset asserted mid-READ at address 3 (between edges)** → all outputs 0 immediately without waiting for an edge. A new start then runs a clean pass with err_cnt=0.
6. **start pulsed during WRITE and a spurious ACK_I during GAP** → both are ignored; the pass matches scenario 1 exactly.
